// File: rtl/instr_mem_fetch.sv
// Instruction store loaded over a write bus, then serving registered fetches to two cores.
// Optional macro INSTR_RR_ARB_EN selects round-robin arbitration; default is fixed core0 priority.
module instr_mem_fetch #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_done,
  output logic              ready,
  output logic [ADDR_W:0]   load_count,
  output logic              wr_ignored,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] pc0,
  input  logic [ADDR_W-1:0] pc1,
  output logic              valid0,
  output logic              valid1,
  output logic [7:0]        opcode0,
  output logic [7:0]        opcode1,
  output logic [7:0]        operand1_0,
  output logic [7:0]        operand1_1,
  output logic [7:0]        operand2_0,
  output logic [7:0]        operand2_1
);

  typedef enum logic {LOADING, SERVE} state_e;

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q;
  logic              ready_q;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_ign_q;
  logic              valid0_q, valid1_q;
  logic [DATA_W-1:0] word0_q, word1_q;
  logic              elig0, elig1, gnt0, gnt1;
  logic [ADDR_W-1:0] rd_addr;
  logic              load_wr;

`ifdef INSTR_RR_ARB_EN
  logic rr_q;  // 0: core0 wins next tie, 1: core1 wins next tie
`endif

  assign load_wr = write_enable && (state_q == LOADING) && !reset;

  always_comb begin
    elig0   = req0 && ready_q && !valid0_q;
    elig1   = req1 && ready_q && !valid1_q;
`ifdef INSTR_RR_ARB_EN
    gnt0    = elig0 && (!elig1 || !rr_q);
    gnt1    = elig1 && (!elig0 ||  rr_q);
`else
    gnt0    = elig0;
    gnt1    = elig1 && !elig0;
`endif
    rd_addr = gnt1 ? pc1 : pc0;
    cnt_d   = cnt_q;
    if (load_wr && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // Storage kept free of reset so contents survive a reload cycle.
  always_ff @(posedge clk) begin
    if (load_wr) mem_q[address] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOADING;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      wr_ign_q <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      word0_q  <= '0;
      word1_q  <= '0;
`ifdef INSTR_RR_ARB_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        LOADING: begin
          if (load_done) begin
            state_q <= SERVE;
            ready_q <= 1'b1;
          end
        end
        SERVE: begin
          if (write_enable) wr_ign_q <= 1'b1;
        end
        default: state_q <= LOADING;
      endcase
      valid0_q <= gnt0;
      valid1_q <= gnt1;
      if (gnt0) word0_q <= mem_q[rd_addr];
      if (gnt1) word1_q <= mem_q[rd_addr];
`ifdef INSTR_RR_ARB_EN
      if (gnt0)      rr_q <= 1'b1;
      else if (gnt1) rr_q <= 1'b0;
`endif
    end
  end

  assign ready      = ready_q;
  assign load_count = cnt_q;
  assign wr_ignored = wr_ign_q;
  assign valid0     = valid0_q;
  assign valid1     = valid1_q;
  assign opcode0    = word0_q[DATA_W-1 -: 8];
  assign operand1_0 = word0_q[15:8];
  assign operand2_0 = word0_q[7:0];
  assign opcode1    = word1_q[DATA_W-1 -: 8];
  assign operand1_1 = word1_q[15:8];
  assign operand2_1 = word1_q[7:0];

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed self-checking bench for instr_mem_fetch: load, fetch, arbitration, reset and saturation.
module tb_instr_mem_fetch;

`ifdef INSTR_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, write_enable, load_done, req0, req1;
  logic [7:0]  address, pc0, pc1;
  logic [23:0] data_in;
  logic        ready, wr_ignored, valid0, valid1;
  logic [8:0]  load_count;
  logic [7:0]  opcode0, opcode1, operand1_0, operand1_1, operand2_0, operand2_1;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_fetch #(.DEPTH(256), .ADDR_W(8), .DATA_W(24)) dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .address(address),
    .data_in(data_in), .load_done(load_done), .ready(ready), .load_count(load_count),
    .wr_ignored(wr_ignored), .req0(req0), .req1(req1), .pc0(pc0), .pc1(pc1),
    .valid0(valid0), .valid1(valid1), .opcode0(opcode0), .opcode1(opcode1),
    .operand1_0(operand1_0), .operand1_1(operand1_1),
    .operand2_0(operand2_0), .operand2_1(operand2_1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w0(input string tag, input logic [23:0] exp);
    chk(tag, {8'h00, opcode0, operand1_0, operand2_0}, {8'h00, exp});
  endtask

  task automatic chk_w1(input string tag, input logic [23:0] exp);
    chk(tag, {8'h00, opcode1, operand1_1, operand2_1}, {8'h00, exp});
  endtask

  task automatic fetch(input bit core, input logic [7:0] pc, input logic [23:0] exp);
    if (core) begin req1 = 1'b1; pc1 = pc; end
    else      begin req0 = 1'b1; pc0 = pc; end
    tick();
    chk("fetch_valid", {31'd0, core ? valid1 : valid0}, 32'd1);
    chk("fetch_other_quiet", {31'd0, core ? valid0 : valid1}, 32'd0);
    if (core) chk_w1("fetch_word1", exp); else chk_w0("fetch_word0", exp);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("fetch_valid_drop", {31'd0, core ? valid1 : valid0}, 32'd0);
    if (core) chk_w1("fetch_hold1", exp); else chk_w0("fetch_hold0", exp);
  endtask

  task automatic contend(input bit first1, input logic [7:0] p0, input logic [7:0] p1,
                         input logic [23:0] e0, input logic [23:0] e1);
    req0 = 1'b1; req1 = 1'b1; pc0 = p0; pc1 = p1;
    tick();
    chk("cont_first_v0", {31'd0, valid0}, {31'd0, !first1});
    chk("cont_first_v1", {31'd0, valid1}, {31'd0, first1});
    if (first1) begin chk_w1("cont_first_w1", e1); req1 = 1'b0; end
    else        begin chk_w0("cont_first_w0", e0); req0 = 1'b0; end
    tick();
    chk("cont_second_v0", {31'd0, valid0}, {31'd0, first1});
    chk("cont_second_v1", {31'd0, valid1}, {31'd0, !first1});
    if (first1) chk_w0("cont_second_w0", e0); else chk_w1("cont_second_w1", e1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("cont_idle", {30'd0, valid0, valid1}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; load_done = 1'b0; req0 = 1'b0; req1 = 1'b0;
    address = '0; data_in = '0; pc0 = '0; pc1 = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_count", {23'd0, load_count}, 32'd0);
    chk("rst_wrign", {31'd0, wr_ignored}, 32'd0);
    chk("rst_valid", {30'd0, valid0, valid1}, 32'd0);
    chk_w0("rst_word0", 24'h0);
    chk_w1("rst_word1", 24'h0);

    // Requests during load are ignored
    req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("load_req_ignored", {31'd0, valid0}, 32'd0);
    end
    req0 = 1'b0;

    write_enable = 1'b1; address = 8'd0; data_in = 24'h010A0B;
    tick();
    address = 8'd1; data_in = 24'h020C0D;
    tick();
    chk("ready_before_done", {31'd0, ready}, 32'd0);
    write_enable = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("load_count2", {23'd0, load_count}, 32'd2);
    chk("ready_after_done", {31'd0, ready}, 32'd1);

    fetch(1'b0, 8'd1, 24'h020C0D);
    fetch(1'b1, 8'd0, 24'h010A0B);
    contend(1'b0, 8'd0, 8'd1, 24'h010A0B, 24'h020C0D);
    fetch(1'b0, 8'd1, 24'h020C0D);
    contend(RR, 8'd0, 8'd1, 24'h010A0B, 24'h020C0D);

    // A held request fetches every other cycle
    req0 = 1'b1; pc0 = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_req_v0", {31'd0, valid0}, {31'd0, (i % 2) == 0});
    end
    req0 = 1'b0;
    tick();

    write_enable = 1'b1; address = 8'd0; data_in = 24'hFFFFFF;
    tick();
    write_enable = 1'b0;
    chk("wr_ignored_set", {31'd0, wr_ignored}, 32'd1);
    chk("count_unchanged", {23'd0, load_count}, 32'd2);
    fetch(1'b0, 8'd0, 24'h010A0B);

    // Reset on the grant edge
    req0 = 1'b1; pc0 = 8'd1; reset = 1'b1;
    tick();
    reset = 1'b0; req0 = 1'b0;
    chk("midrst_valid0", {31'd0, valid0}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_count", {23'd0, load_count}, 32'd0);
    chk("midrst_wrign", {31'd0, wr_ignored}, 32'd0);
    chk_w0("midrst_word0", 24'h0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("reload_ready", {31'd0, ready}, 32'd1);
    fetch(1'b0, 8'd1, 24'h020C0D);

    // Saturation: 300 writes with wrapping address
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      address = 8'(i);
      data_in = 24'(i);
      tick();
      if (i == 254) chk("count_255", {23'd0, load_count}, 32'd255);
      if (i == 255) chk("count_256", {23'd0, load_count}, 32'd256);
    end
    write_enable = 1'b0;
    chk("count_saturated", {23'd0, load_count}, 32'd256);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    contend(1'b0, 8'd5, 8'd255, 24'h000105, 24'h0000FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
